// File: rtl/tpu_pkg.sv
// Shared TPU constants, requester indices and the memory-arbiter FSM encoding.
// The optional WAIT watchdog in mem_access_arbiter is enabled by MEM_ARB_TIMEOUT_EN.
package tpu_pkg;

  localparam int unsigned NUM_REQ     = 3;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DIM_W       = 5;
  localparam int unsigned TIMEOUT_CYC = 64;

  localparam int unsigned REQ_WEIGHT = 0;
  localparam int unsigned REQ_INPUT  = 1;
  localparam int unsigned REQ_OUTPUT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping around, returned as a one-hot select plus a valid flag.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_sel,
  output logic               o_valid
);

  logic w_found;

  // Walk offsets from the pointer; the first requesting slot wins.
  always_comb begin
    o_sel   = '0;
    w_found = 1'b0;
    for (int off = 0; off < int'(NUM_REQ); off++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!w_found && i_req[i] &&
            (((int'(i_ptr) + off) % int'(NUM_REQ)) == i)) begin
          o_sel[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory controller among NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to add the WAIT-state watchdog and sticky err flag.
module mem_access_arbiter
  import tpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = tpu_pkg::NUM_REQ,
  parameter int unsigned ADDR_W  = tpu_pkg::ADDR_W,
  parameter int unsigned DIM_W   = tpu_pkg::DIM_W
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = tpu_pkg::TIMEOUT_CYC
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_base_addr,
  input  logic [NUM_REQ*DIM_W-1:0]   req_num_row,
  input  logic [NUM_REQ*DIM_W-1:0]   req_num_col,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       mem_active,
  output logic [ADDR_W-1:0]          mem_base_addr,
  output logic [DIM_W-1:0]           mem_num_row,
  output logic [DIM_W-1:0]           mem_num_col,
  input  logic                       mem_done,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
`endif

  arb_state_e          r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]  r_req_done, w_req_done_nxt;
  logic                r_active, w_active_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_zero, w_zero_nxt;
  logic                w_finish;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DIM_W-1:0]    r_row, w_row_nxt;
  logic [DIM_W-1:0]    r_col, w_col_nxt;
  logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]    r_gidx, w_gidx_nxt;

  logic [NUM_REQ-1:0]  w_sel;
  logic                w_valid;
  logic [PTR_W-1:0]    w_pick_idx;
  logic [ADDR_W-1:0]   w_pick_addr;
  logic [DIM_W-1:0]    w_pick_row;
  logic [DIM_W-1:0]    w_pick_col;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_err, w_err_nxt;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_sel   (w_sel),
    .o_valid (w_valid)
  );

  // Fetch the winning requester's index and transaction fields.
  always_comb begin
    w_pick_idx  = '0;
    w_pick_addr = '0;
    w_pick_row  = '0;
    w_pick_col  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_sel[i]) begin
        w_pick_idx  = PTR_W'(i);
        w_pick_addr = req_base_addr[i*ADDR_W +: ADDR_W];
        w_pick_row  = req_num_row[i*DIM_W +: DIM_W];
        w_pick_col  = req_num_col[i*DIM_W +: DIM_W];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_req_done_nxt = '0;
    w_active_nxt   = 1'b0;
    w_zero_nxt     = r_zero;
    w_addr_nxt     = r_addr;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_ptr_nxt      = r_ptr;
    w_gidx_nxt     = r_gidx;
    w_finish       = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = r_err;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_grant_nxt = w_sel;
          w_gidx_nxt  = w_pick_idx;
          w_addr_nxt  = w_pick_addr;
          w_row_nxt   = w_pick_row;
          w_col_nxt   = w_pick_col;
          w_zero_nxt  = (w_pick_row == '0) || (w_pick_col == '0);
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // An empty tile never starts the controller; WAIT then completes at once.
        w_active_nxt = ~r_zero;
`ifdef MEM_ARB_TIMEOUT_EN
        w_cnt_nxt    = '0;
`endif
        w_state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_zero || mem_done) begin
          w_finish = 1'b1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_finish  = 1'b1;
          w_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        w_ptr_nxt   = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_finish) begin
      w_req_done_nxt = r_grant;
      w_grant_nxt    = '0;
      w_state_nxt    = ST_DONE;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_req_done <= '0;
      r_active   <= 1'b0;
      r_busy     <= 1'b0;
      r_zero     <= 1'b0;
      r_addr     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_ptr      <= '0;
      r_gidx     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_req_done <= w_req_done_nxt;
      r_active   <= w_active_nxt;
      r_busy     <= w_busy_nxt;
      r_zero     <= w_zero_nxt;
      r_addr     <= w_addr_nxt;
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gidx     <= w_gidx_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  assign grant         = r_grant;
  assign req_done      = r_req_done;
  assign mem_active    = r_active;
  assign mem_base_addr = r_addr;
  assign mem_num_row   = r_row;
  assign mem_num_col   = r_col;
  assign busy          = r_busy;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err           = r_err;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus randomized traffic
// against a round-robin reference model; MEM_ARB_TIMEOUT_EN selects the watchdog scenario.
module tb_mem_access_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 5;
  localparam int TO = 64;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_base_addr;
  logic [N*DW-1:0]   req_num_row;
  logic [N*DW-1:0]   req_num_col;
  logic [N-1:0]      grant;
  logic [N-1:0]      req_done;
  logic              mem_active;
  logic [AW-1:0]     mem_base_addr;
  logic [DW-1:0]     mem_num_row;
  logic [DW-1:0]     mem_num_col;
  logic              mem_done;
  logic              busy;
  logic              err;

  // Reference model state: pending requests, their fields, RR pointer, sticky error.
  logic [AW-1:0]     m_addr [N];
  int                m_row  [N];
  int                m_col  [N];
  logic [N-1:0]      pend;
  int                m_ptr;
  logic              exp_err;

  int n_checks;
  int n_errors;

  mem_access_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_base_addr (req_base_addr),
    .req_num_row   (req_num_row),
    .req_num_col   (req_num_col),
    .grant         (grant),
    .req_done      (req_done),
    .mem_active    (mem_active),
    .mem_base_addr (mem_base_addr),
    .mem_num_row   (mem_num_row),
    .mem_num_col   (mem_num_col),
    .mem_done      (mem_done),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic chk_outs(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ed,
                          input logic ea, input logic eb);
    chk({tag, ".grant"},    32'(grant),      32'(eg));
    chk({tag, ".req_done"}, 32'(req_done),   32'(ed));
    chk({tag, ".active"},   32'(mem_active), 32'(ea));
    chk({tag, ".busy"},     32'(busy),       32'(eb));
    chk({tag, ".err"},      32'(err),        32'(exp_err));
  endtask

  task automatic chk_zero(input string tag);
    chk_outs(tag, '0, '0, 1'b0, 1'b0);
    chk({tag, ".addr"}, 32'(mem_base_addr), 32'(0));
    chk({tag, ".row"},  32'(mem_num_row),   32'(0));
    chk({tag, ".col"},  32'(mem_num_col),   32'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (p[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic int rnd_dim();
    if ($urandom_range(0, 7) == 0) return 0;
    return int'($urandom_range(1, 16));
  endfunction

  task automatic raise(input int i, input logic [AW-1:0] a, input int r, input int c);
    m_addr[i] = a;
    m_row[i]  = r;
    m_col[i]  = c;
    pend[i]   = 1'b1;
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      req_base_addr[i*AW +: AW] = m_addr[i];
      req_num_row[i*DW +: DW]   = DW'(m_row[i]);
      req_num_col[i*DW +: DW]   = DW'(m_col[i]);
    end
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b0;
    req      = '0;
    mem_done = 1'b0;
    pend     = '0;
    m_ptr    = 0;
    exp_err  = 1'b0;
    #1;
    chk_zero({tag, ".in_reset"});
    step();
    chk_zero({tag, ".held"});
    reset = 1'b1;
  endtask

  // mem_done pulsed while the arbiter is idle must leave it idle.
  task automatic idle_stray(input string tag);
    req      = '0;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk_outs(tag, '0, '0, 1'b0, 1'b0);
  endtask

  // One full transaction from IDLE; lat = WAIT cycles before mem_done.
  task automatic run_txn(input string tag, input int lat, input logic stray_issue, output int g);
    logic [N-1:0] oh;
    logic         zero;
    drive_fields();
    req = pend;
    g   = pick(pend, m_ptr);
    if (g < 0) begin
      chk({tag, ".no_request"}, 32'(pend), 32'(1));
      g = 0;
      return;
    end
    oh    = '0;
    oh[g] = 1'b1;
    zero  = (m_row[g] == 0) || (m_col[g] == 0);

    step();
    chk_outs({tag, ".grant"}, oh, '0, 1'b0, 1'b1);
    chk({tag, ".addr"}, 32'(mem_base_addr), 32'(m_addr[g]));
    chk({tag, ".row"},  32'(mem_num_row),   32'(m_row[g]));
    chk({tag, ".col"},  32'(mem_num_col),   32'(m_col[g]));

    mem_done = stray_issue;
    step();
    mem_done = 1'b0;
    chk_outs({tag, ".issue"}, oh, '0, ~zero, 1'b1);

    if (!zero) begin
      for (int j = 0; j < lat; j++) begin
        step();
        chk_outs({tag, ".wait"}, oh, '0, 1'b0, 1'b1);
      end
    end

    mem_done = ~zero;
    step();
    mem_done = 1'b0;
    chk_outs({tag, ".done"}, '0, oh, 1'b0, 1'b1);
    chk({tag, ".addr_held"}, 32'(mem_base_addr), 32'(m_addr[g]));

    pend[g] = 1'b0;
    req     = pend;
    step();
    chk_outs({tag, ".idle"}, '0, '0, 1'b0, 1'b0);
    m_ptr = (g + 1) % N;
  endtask

  initial begin
    int g;
    n_checks      = 0;
    n_errors      = 0;
    req           = '0;
    req_base_addr = '0;
    req_num_row   = '0;
    req_num_col   = '0;
    mem_done      = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_addr[i] = '0;
      m_row[i]  = 0;
      m_col[i]  = 0;
    end

    do_reset("reset0");

    // Single request, full 16x16 tile at address 0.
    raise(0, 8'h00, 16, 16);
    run_txn("single", 5, 1'b0, g);

    // Round-robin with all three requesters continuously requesting.
    do_reset("reset_rr");
    raise(0, 8'h10, 4, 4);
    raise(1, 8'h20, 4, 4);
    raise(2, 8'h30, 4, 4);
    for (int k = 0; k < 4; k++) begin
      run_txn("rr", 3, 1'b0, g);
      raise(g, m_addr[g], 4, 4);
    end
    pend = '0;
    req  = '0;
    step();

    // Zero-column tile: completes without starting the controller.
    raise(1, 8'h44, 7, 0);
    run_txn("zero_dim", 0, 1'b0, g);

    // Stray mem_done in IDLE and in ISSUE.
    idle_stray("stray_idle");
    raise(2, 8'h5a, 3, 9);
    run_txn("stray_issue", 2, 1'b1, g);

    // Reset in WAIT abandons the transaction and clears the pointer.
    do_reset("reset_mid");
    raise(0, 8'h11, 2, 2);
    run_txn("pre_mid", 1, 1'b0, g);
    raise(0, 8'h22, 5, 5);
    drive_fields();
    req = pend;
    step();
    chk_outs("mid.grant", 3'b001, '0, 1'b0, 1'b1);
    step();
    step();
    chk_outs("mid.wait", 3'b001, '0, 1'b0, 1'b1);
    do_reset("mid_abort");
    raise(0, 8'h66, 3, 3);
    raise(2, 8'h77, 3, 3);
    run_txn("post_mid_a", 1, 1'b0, g);
    run_txn("post_mid_b", 1, 1'b0, g);

    // Randomized traffic.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          raise(i, AW'($urandom), rnd_dim(), rnd_dim());
        else if (pend[i] && $urandom_range(0, 7) == 0)
          pend[i] = 1'b0;
      end
      if (pend == '0) raise(int'($urandom_range(0, N - 1)), AW'($urandom), rnd_dim(), rnd_dim());
      if ($urandom_range(0, 3) == 0) idle_stray("rand_stray");
      run_txn("rand", int'($urandom_range(0, 6)), logic'($urandom_range(0, 3) == 0), g);
    end

    // Withheld mem_done: watchdog when enabled, otherwise an indefinite WAIT.
    do_reset("reset_to");
    raise(0, 8'h99, 8, 8);
    drive_fields();
    req = pend;
    step();
    step();
    chk_outs("to.issue", 3'b001, '0, 1'b1, 1'b1);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int j = 1; j < TO; j++) begin
      step();
      chk_outs("to.wait", 3'b001, '0, 1'b0, 1'b1);
    end
    exp_err = 1'b1;
    step();
    chk_outs("to.fire", '0, 3'b001, 1'b0, 1'b1);
`else
    for (int j = 0; j < TO + 16; j++) step();
    chk_outs("to.hold", 3'b001, '0, 1'b0, 1'b1);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk_outs("to.done", '0, 3'b001, 1'b0, 1'b1);
`endif
    pend = '0;
    req  = '0;
    step();
    chk_outs("to.idle", '0, '0, 1'b0, 1'b0);
    m_ptr = 1;
    for (int t = 0; t < 3; t++) begin
      raise(t, AW'($urandom), int'($urandom_range(1, 16)), int'($urandom_range(1, 16)));
      run_txn("after_to", 2, 1'b0, g);
    end
    do_reset("reset_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
